// File: rtl/rs_pkg.sv
// Shared constants and helpers for the RS decode path.
package rs_pkg;

   localparam int unsigned RS_SYM_W   = 8;
   localparam int unsigned RS_CW_SYMS = 194;
   localparam int unsigned RS_DW      = 64;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   localparam int unsigned RS_NSYM_W = clog2(RS_DW / RS_SYM_W + 1);

   typedef logic [RS_NSYM_W-1:0] rs_nsym_t;

endpackage

// File: rtl/rs_sym_shifter.sv
// Joins the residue with an input beat and cuts out one MSB-first, zero-padded output beat.
module rs_sym_shifter
   import rs_pkg::*;
#(
   parameter int unsigned DW    = 64,
   parameter int unsigned SYM_W = RS_SYM_W,
   parameter int unsigned NW    = clog2(DW / SYM_W + 1)
) (
   input  logic [DW-SYM_W-1:0] res_i,
   input  logic [NW-1:0]       r_i,
   input  logic [DW-1:0]       data_i,
   input  logic [NW-1:0]       need_i,
   output logic [DW-1:0]       data_o,
   output logic [DW-SYM_W-1:0] res_o
);

   localparam int unsigned NS = DW / SYM_W;
   localparam int unsigned RW = DW - SYM_W;
   localparam int unsigned BW = DW + RW;

   logic [BW-1:0] buf_w;
   logic [DW-1:0] mask_w;

   always_comb begin
      // Residue sits at the top; the input beat lands right after the r_i held symbols.
      buf_w  = {res_i, {DW{1'b0}}} |
               ({{RW{1'b0}}, data_i} << ((NS - 1 - 32'(r_i)) * SYM_W));
      mask_w = ~({DW{1'b1}} >> (32'(need_i) * SYM_W));
      data_o = DW'(buf_w >> RW) & mask_w;
      res_o  = RW'((buf_w << (32'(need_i) * SYM_W)) >> DW);
   end

endmodule

// File: rtl/rs_cw_framer.sv
// Re-cuts a continuous symbol stream into codeword-aligned beats with sop/eop/nsym.
// Optional stats (cw_cnt, ovf_drop) when RS_FRAMER_STATS_EN is defined.
module rs_cw_framer
   import rs_pkg::*;
#(
   parameter int unsigned DW       = 64,
   parameter int unsigned SYM_W    = RS_SYM_W,
   parameter int unsigned CW_SYMS  = RS_CW_SYMS,
   localparam int unsigned NS      = DW / SYM_W,
   localparam int unsigned NW      = clog2(NS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rs_ena,
   input  logic          flush,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [DW-1:0] in_data,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_data,
   output logic          out_sop,
   output logic          out_eop,
   output logic [NW-1:0] out_nsym
`ifdef RS_FRAMER_STATS_EN
   ,
   output logic [31:0]   cw_cnt,
   output logic          ovf_drop
`endif
);

   localparam int unsigned CW_W = clog2(CW_SYMS + 1);
   localparam int unsigned RW   = DW - SYM_W;
   localparam logic [CW_W-1:0] CW_FULL = CW_W'(CW_SYMS);

   logic          out_vld_d, out_vld_q, out_sop_d, out_sop_q, out_eop_d, out_eop_q;
   logic [DW-1:0] out_data_d, out_data_q;
   logic [NW-1:0] out_nsym_d, out_nsym_q;
   logic [RW-1:0] res_d, res_q;
   logic [NW-1:0] r_d, r_q;
   logic [CW_W-1:0] c_d, c_q;
   logic          mode_d, mode_q;

   logic          adv, at_bound, mode_eff, from_res, hs, fr_emit, eop_now, emit_fire;
   logic [NW-1:0] need;
   logic [DW-1:0] sh_in, sh_data;
   logic [RW-1:0] sh_res;

   always_comb begin
      adv       = ~out_vld_q | out_rdy;
      at_bound  = (r_q == '0) && (c_q == CW_FULL);
      // Mode only switches between codewords.
      mode_eff  = at_bound ? rs_ena : mode_q;
      need      = (32'(c_q) >= NS) ? NW'(NS) : NW'(c_q);
      from_res  = (r_q >= need);
      in_rdy    = ~rst & ~flush & adv & ~(mode_eff & from_res);
      hs        = in_vld & in_rdy;
      fr_emit   = mode_eff & (from_res | hs);
      eop_now   = (32'(need) == 32'(c_q));
      emit_fire = ~flush & adv & fr_emit;
      sh_in     = from_res ? '0 : in_data;
   end

   rs_sym_shifter #(
      .DW    (DW),
      .SYM_W (SYM_W),
      .NW    (NW)
   ) u_shifter (
      .res_i  (res_q),
      .r_i    (r_q),
      .data_i (sh_in),
      .need_i (need),
      .data_o (sh_data),
      .res_o  (sh_res)
   );

   always_comb begin
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_sop_d  = out_sop_q;
      out_eop_d  = out_eop_q;
      out_nsym_d = out_nsym_q;
      res_d      = res_q;
      r_d        = r_q;
      c_d        = c_q;
      mode_d     = mode_eff;
      if (flush) begin
         out_vld_d = 1'b0;
         res_d     = '0;
         r_d       = '0;
         c_d       = CW_FULL;
      end else if (adv) begin
         if (!mode_eff) begin
            out_vld_d = hs;
            if (hs) begin
               out_data_d = in_data;
               out_sop_d  = 1'b0;
               out_eop_d  = 1'b0;
               out_nsym_d = NW'(NS);
            end
         end else if (fr_emit) begin
            out_vld_d  = 1'b1;
            out_data_d = sh_data;
            out_sop_d  = (c_q == CW_FULL);
            out_eop_d  = eop_now;
            out_nsym_d = need;
            res_d      = sh_res;
            r_d        = from_res ? NW'(r_q - need) : NW'(32'(r_q) + NS - 32'(need));
            c_d        = eop_now ? CW_FULL : CW_W'(32'(c_q) - 32'(need));
         end else begin
            out_vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_sop_q  <= 1'b0;
         out_eop_q  <= 1'b0;
         out_nsym_q <= '0;
         res_q      <= '0;
         r_q        <= '0;
         c_q        <= CW_FULL;
         mode_q     <= rs_ena;
      end else begin
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_sop_q  <= out_sop_d;
         out_eop_q  <= out_eop_d;
         out_nsym_q <= out_nsym_d;
         res_q      <= res_d;
         r_q        <= r_d;
         c_q        <= c_d;
         mode_q     <= mode_d;
      end
   end

   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;
   assign out_sop  = out_sop_q;
   assign out_eop  = out_eop_q;
   assign out_nsym = out_nsym_q;

`ifdef RS_FRAMER_STATS_EN
   logic [31:0] cw_cnt_d, cw_cnt_q;
   logic        ovf_drop_d, ovf_drop_q;

   always_comb begin
      cw_cnt_d   = cw_cnt_q;
      if (emit_fire && eop_now) cw_cnt_d = cw_cnt_q + 32'd1;
      ovf_drop_d = flush & ((out_vld_q & ~out_rdy) | ~at_bound);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cw_cnt_q   <= '0;
         ovf_drop_q <= 1'b0;
      end else begin
         cw_cnt_q   <= cw_cnt_d;
         ovf_drop_q <= ovf_drop_d;
      end
   end

   assign cw_cnt   = cw_cnt_q;
   assign ovf_drop = ovf_drop_q;
`endif

endmodule

// File: tb/tb_rs_cw_framer.sv
// Directed bench for rs_cw_framer: default 64-bit/194-symbol instance plus a 32-bit/7-symbol one.
// Stats checks are included when RS_FRAMER_STATS_EN is defined.
module tb_rs_cw_framer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rs_ena = 1'b1;
   logic        flush = 1'b0;
   logic        in_vld = 1'b0, in_rdy, out_vld, out_rdy = 1'b1, out_sop, out_eop;
   logic [63:0] in_data = '0, out_data;
   logic [3:0]  out_nsym;
   logic        in_vld32 = 1'b0, in_rdy32, out_vld32, out_rdy32 = 1'b1, out_sop32, out_eop32;
   logic [31:0] in_data32 = '0, out_data32;
   logic [2:0]  out_nsym32;
`ifdef RS_FRAMER_STATS_EN
   logic [31:0] cw_cnt, cw_cnt32;
   logic        ovf_drop, ovf_drop32;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          idx;
      logic        sop;
      logic        eop;
      logic [3:0]  nsym;
      logic [63:0] data;
   } vec_t;

   vec_t        tbl [10];
   logic [79:0] cap [100];

   always #5 clk = ~clk;

   rs_cw_framer u_dut (
      .clk      (clk),
      .rst      (rst),
      .rs_ena   (rs_ena),
      .flush    (flush),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .in_data  (in_data),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .out_sop  (out_sop),
      .out_eop  (out_eop),
      .out_nsym (out_nsym)
`ifdef RS_FRAMER_STATS_EN
      ,
      .cw_cnt   (cw_cnt),
      .ovf_drop (ovf_drop)
`endif
   );

   rs_cw_framer #(
      .DW      (32),
      .SYM_W   (8),
      .CW_SYMS (7)
   ) u_dut32 (
      .clk      (clk),
      .rst      (rst),
      .rs_ena   (1'b1),
      .flush    (1'b0),
      .in_vld   (in_vld32),
      .in_rdy   (in_rdy32),
      .in_data  (in_data32),
      .out_vld  (out_vld32),
      .out_rdy  (out_rdy32),
      .out_data (out_data32),
      .out_sop  (out_sop32),
      .out_eop  (out_eop32),
      .out_nsym (out_nsym32)
`ifdef RS_FRAMER_STATS_EN
      ,
      .cw_cnt   (cw_cnt32),
      .ovf_drop (ovf_drop32)
`endif
   );

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [79:0] pack64();
      return {9'b0, out_vld, out_sop, out_eop, out_nsym, out_data};
   endfunction

   function automatic logic [79:0] beat64(input logic sop, input logic eop, input logic [3:0] n,
                                          input logic [63:0] d);
      return {9'b0, 1'b1, sop, eop, n, d};
   endfunction

   function automatic logic [63:0] ramp64(input int k);
      logic [63:0] d;
      for (int i = 0; i < 8; i++) d[63-8*i -: 8] = 8'(8 * k + i);
      return d;
   endfunction

   // Reference for the default instance: byte ramp cut into 194-symbol codewords.
   function automatic logic [79:0] exp64(input int j);
      int cw, b, n, s0;
      logic [63:0] d;
      cw = j / 25;
      b  = j % 25;
      n  = (b < 24) ? 8 : 2;
      s0 = 194 * cw + 8 * b;
      d  = '0;
      for (int i = 0; i < n; i++) d[63-8*i -: 8] = 8'(s0 + i);
      return beat64(b == 0, b == 24, 4'(n), d);
   endfunction

   function automatic logic [7:0] sym32(input int s);
      return 8'(s * 37 + 11);
   endfunction

   function automatic logic [31:0] in32(input int k);
      logic [31:0] d;
      for (int i = 0; i < 4; i++) d[31-8*i -: 8] = sym32(4 * k + i);
      return d;
   endfunction

   function automatic logic [79:0] exp32(input int j);
      int cw, b, n, s0;
      logic [31:0] d;
      cw = j / 2;
      b  = j % 2;
      n  = (b == 0) ? 4 : 3;
      s0 = 7 * cw + 4 * b;
      d  = '0;
      for (int i = 0; i < n; i++) d[31-8*i -: 8] = sym32(s0 + i);
      return {42'b0, 1'b1, b == 0, b == 1, 3'(n), d};
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b1;
      in_vld32 = 1'b0; out_rdy32 = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic send64(input logic [63:0] d);
      int n = 0;
      in_vld  = 1'b1;
      in_data = d;
      #4;
      while (!in_rdy && n < 20) begin
         tick();
         #4;
         n++;
      end
      if (!in_rdy) chk("send_timeout", 80'(in_rdy), 80'(1'b1));
      tick();
      in_vld = 1'b0;
   endtask

   // Streams 97 ramp beats, collects 100 output beats.
   task automatic run_frame(input int unsigned stall_pct, input bit chk_rdy, input bit use_model);
      int k = 0, j = 0, cyc = 0, low = 0;
      bit want_eop = 1'b0, held = 1'b0;
      logic [79:0] saved = '0;
      while (j < 100 && cyc < 1000) begin
         in_vld  = (k < 97);
         in_data = ramp64(k);
         out_rdy = ($urandom_range(0, 99) >= stall_pct);
         #4;
         if (held) chk("stall_hold", pack64(), saved);
         if (want_eop) chk("eop_after_rdy_low", 80'({out_vld, out_eop}), 80'(2'b11));
         want_eop = 1'b0;
         if (chk_rdy && !in_rdy) begin
            low++;
            want_eop = 1'b1;
         end
         held  = out_vld && !out_rdy;
         saved = pack64();
         if (out_vld && out_rdy) begin
            cap[j] = pack64();
            if (use_model) chk("beat", pack64(), exp64(j));
            j++;
         end
         if (in_vld && in_rdy) k++;
         tick();
         cyc++;
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      chk("n_beats", 80'(j), 80'(100));
      chk("n_inputs", 80'(k), 80'(97));
      if (chk_rdy) chk("rdy_low_cycles", 80'(low), 80'(3));
   endtask

   initial begin
      logic [63:0] d;
      logic [7:0]  b;
      int k, j, cyc;

      tbl[0] = '{0,  1'b1, 1'b0, 4'd8, 64'h0001020304050607};
      tbl[1] = '{1,  1'b0, 1'b0, 4'd8, 64'h08090A0B0C0D0E0F};
      tbl[2] = '{23, 1'b0, 1'b0, 4'd8, 64'hB8B9BABBBCBDBEBF};
      tbl[3] = '{24, 1'b0, 1'b1, 4'd2, 64'hC0C1000000000000};
      tbl[4] = '{25, 1'b1, 1'b0, 4'd8, 64'hC2C3C4C5C6C7C8C9};
      tbl[5] = '{49, 1'b0, 1'b1, 4'd2, 64'h8283000000000000};
      tbl[6] = '{50, 1'b1, 1'b0, 4'd8, 64'h8485868788898A8B};
      tbl[7] = '{74, 1'b0, 1'b1, 4'd2, 64'h4445000000000000};
      tbl[8] = '{75, 1'b1, 1'b0, 4'd8, 64'h464748494A4B4C4D};
      tbl[9] = '{99, 1'b0, 1'b1, 4'd2, 64'h0607000000000000};

      // Reset state
      rst = 1'b1;
      tick();
      #4;
      chk("rst_in_rdy", 80'(in_rdy), 80'(1'b0));
      tick();
      rst = 1'b0;
      chk("rst_outputs", pack64(), 80'(0));
      #1;
      chk("rdy_after_rst", 80'(in_rdy), 80'(1'b1));

      // Continuous framing, table of hand-computed beats
      run_frame(0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("tbl_beat%0d", tbl[i].idx), cap[tbl[i].idx],
             beat64(tbl[i].sop, tbl[i].eop, tbl[i].nsym, tbl[i].data));
      end
`ifdef RS_FRAMER_STATS_EN
      chk("cw_cnt", 80'(cw_cnt), 80'(4));
`endif

      // Same stream under random downstream stalls
      do_reset();
      run_frame(30, 1'b0, 1'b1);

      // Pass-through, then switch to framing at the boundary
      rs_ena = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         b = 8'(i * 17 + 1);
         d = 64'h0123456789ABCDEF ^ {8{b}};
         send64(d);
         chk("pt_beat", pack64(), beat64(1'b0, 1'b0, 4'd8, d));
      end
      rs_ena = 1'b1;
      send64(64'hFEDCBA9876543210);
      chk("mode_switch_sop", pack64(), beat64(1'b1, 1'b0, 4'd8, 64'hFEDCBA9876543210));

      // Flush mid-codeword
      do_reset();
      for (int i = 0; i < 30; i++) send64(ramp64(i));
      in_vld  = 1'b1;
      in_data = 64'hDEADBEEFDEADBEEF;
      flush   = 1'b1;
      #4;
      chk("flush_in_rdy", 80'(in_rdy), 80'(1'b0));
      tick();
      flush  = 1'b0;
      in_vld = 1'b0;
      chk("flush_out_vld", 80'(out_vld), 80'(1'b0));
`ifdef RS_FRAMER_STATS_EN
      chk("ovf_drop_pulse", 80'(ovf_drop), 80'(1'b1));
`endif
      send64(64'h1122334455667788);
      chk("post_flush_sop", pack64(), beat64(1'b1, 1'b0, 4'd8, 64'h1122334455667788));
`ifdef RS_FRAMER_STATS_EN
      chk("ovf_drop_clear", 80'(ovf_drop), 80'(1'b0));
`endif

      // Reset mid-codeword with a valid output beat
      do_reset();
      for (int i = 0; i < 3; i++) send64(ramp64(i));
      chk("pre_rst_vld", 80'(out_vld), 80'(1'b1));
      rst     = 1'b1;
      in_vld  = 1'b1;
      in_data = 64'hAAAA5555AAAA5555;
      #4;
      chk("mid_rst_in_rdy", 80'(in_rdy), 80'(1'b0));
      tick();
      rst    = 1'b0;
      in_vld = 1'b0;
      chk("mid_rst_clears", pack64(), 80'(0));
`ifdef RS_FRAMER_STATS_EN
      chk("mid_rst_cw_cnt", 80'(cw_cnt), 80'(0));
`endif
      send64(64'h0F1E2D3C4B5A6978);
      chk("post_rst_sop", pack64(), beat64(1'b1, 1'b0, 4'd8, 64'h0F1E2D3C4B5A6978));

      // 32-bit bus, 7-symbol codewords, random gaps on both sides
      do_reset();
      k = 0;
      j = 0;
      cyc = 0;
      while (j < 1000 && cyc < 8000) begin
         in_vld32  = (k < 875) && ($urandom_range(0, 9) < 8);
         in_data32 = in32(k);
         out_rdy32 = ($urandom_range(0, 9) >= 3);
         #4;
         if (out_vld32 && out_rdy32) begin
            chk("beat32", {42'b0, out_vld32, out_sop32, out_eop32, out_nsym32, out_data32},
                exp32(j));
            j++;
         end
         if (in_vld32 && in_rdy32) k++;
         tick();
         cyc++;
      end
      in_vld32 = 1'b0;
      chk("n_beats32", 80'(j), 80'(1000));
      chk("n_inputs32", 80'(k), 80'(875));
`ifdef RS_FRAMER_STATS_EN
      chk("cw_cnt32", 80'(cw_cnt32), 80'(500));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
